gmux_sel_ctrl: RTL
==================

GMUX_SEL_CTRL -- requirements
Module: gmux_sel_ctrl

Interface
REQ-001 SHALL have parameter GATE_CYC, default 2, meaning cycles with all quadrants gated before SSEL changes (legal range 1..15).
REQ-002 SHALL have parameter SETTLE_CYC, default 4, meaning cycles after an SSEL change or low-power exit before quadrants are re-enabled (legal range 1..15).
REQ-003 SHALL have ports: CLK  in  1  sole clock, rising edge.
REQ-004 SHALL have ports: RST  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports: REQ_VALID  in  1  reconfiguration request.
REQ-006 SHALL have ports: REQ_SRC  in  1  requested source (0=GCLKIN, 1=GHSCK).
REQ-007 SHALL have ports: REQ_QEN  in  4  requested quadrant enable mask.
REQ-008 SHALL have ports: REQ_READY  out  1  request accepted when high together with REQ_VALID.
REQ-009 SHALL have ports: DONE  out  1  one-cycle completion pulse.
REQ-010 SHALL have ports: LP_REQ  in  1  level low-power request.
REQ-011 SHALL have ports: BUSY  out  1  high when state is not IDLE.
REQ-012 SHALL have ports: SSEL  out  1  GMUX source select.
REQ-013 SHALL have ports: SEN, DEN, DYNEN, VLP  out  4 each  quadrant controls; bit 0=TL, 1=TR, 2=BL, 3=BR.

Function
REQ-014 States SHALL be IDLE, GATE, SETTLE, LP; all outputs SHALL be registered except REQ_READY (high only in IDLE with RST low) and BUSY.
REQ-015 REQ_SRC, REQ_QEN SHALL be latched on the accepting edge (REQ_VALID && REQ_READY).
REQ-016 Accepted REQ_SRC equal to current SSEL: on the accepting edge SEN SHALL load REQ_QEN, DONE SHALL pulse for one cycle, state SHALL stay IDLE.
REQ-017 Accepted REQ_SRC different from SSEL: on the accepting edge SEN SHALL go 4'h0, state GATE, counter loads GATE_CYC-1.
REQ-018 In GATE/SETTLE the counter SHALL decrement each edge; on an edge seeing zero in GATE, SSEL SHALL load latched REQ_SRC, state SETTLE, counter loads SETTLE_CYC-1.
REQ-019 On an edge seeing zero in SETTLE, SEN SHALL load the latched mask, DONE SHALL pulse one cycle, state IDLE; accept-to-DONE latency SHALL be GATE_CYC+SETTLE_CYC edges.
REQ-020 SSEL SHALL never change while any SEN bit is 1.
REQ-021 DYNEN SHALL equal the latched mask during GATE and SETTLE, else 4'h0; DEN SHALL be constant 4'h0.
REQ-022 In IDLE, LP_REQ high with REQ_VALID low SHALL enter LP: SEN 4'h0, VLP 4'hF; REQ_VALID SHALL take priority over LP_REQ on the same edge.
REQ-023 In LP, LP_REQ low SHALL clear VLP, enter SETTLE with counter SETTLE_CYC-1 and SSEL unchanged, then restore the last mask without a DONE pulse.
REQ-024 REQ_VALID while not IDLE SHALL be ignored (REQ_READY low); requester SHALL hold it.

Reset
REQ-025 RST high SHALL asynchronously force: state IDLE, counter 0, SSEL 0, SEN 4'hF, DEN/DYNEN/VLP 4'h0, DONE 0, stored mask 4'hF; REQ_READY SHALL be 0 while RST is high.
REQ-026 Reset mid-sequence SHALL abort with no DONE pulse; the first accept SHALL be possible on the first edge after RST falls.

Structure
REQ-027 Package gmux_ctrl_pkg SHALL hold the state enum, quadrant bit indices (TL=0, TR=1, BL=2, BR=3) and reset constants for SEN/SSEL.
REQ-028 A sub-module gmux_dwell_cnt (4-bit loadable down-counter with zero flag) SHALL implement the counter.

Verification
REQ-029 Reset release, REQ_SRC=1, REQ_QEN=4'hF, defaults -> SEN 0 for 6 cycles, SSEL rises 2 edges after accept, SEN=4'hF and DONE pulse 6 edges after accept.
REQ-030 REQ_SRC=0 with SSEL=0, REQ_QEN=4'h5 -> SEN=4'h5 and DONE on the accepting edge, SSEL constant, BUSY never high.
REQ-031 LP_REQ high 10 cycles from IDLE with mask 4'h3 -> VLP=4'hF, SEN=0; after LP_REQ low VLP=0, SEN=4'h3 4 edges later, no DONE.
REQ-032 Simultaneous REQ_VALID (REQ_SRC=1) and LP_REQ in IDLE -> switch sequence runs, LP entered only after DONE if LP_REQ is still high.
REQ-033 RST asserted mid-SETTLE -> outputs immediately at reset values, no DONE; new request after release completes normally.
REQ-034 Assertion throughout all tests: SSEL toggles only when SEN=4'h0; REQ_READY low whenever BUSY high.

Source files
------------

// File: rtl/gmux_ctrl_pkg.sv
// rtl/gmux_ctrl_pkg.sv - shared types and constants for the GMUX select controller
//
// Purpose: FSM state encoding, quadrant bit indices and reset values used by
//          gmux_sel_ctrl and its dwell counter.
package gmux_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GATE   = 2'd1,
    ST_SETTLE = 2'd2,
    ST_LP     = 2'd3
  } gmux_state_e;

  // Quadrant bit positions in every 4-bit quadrant vector
  localparam int Q_TL = 0;
  localparam int Q_TR = 1;
  localparam int Q_BL = 2;
  localparam int Q_BR = 3;

  localparam logic [3:0] Q_NONE   = 4'h0;
  localparam logic [3:0] Q_ALL    = 4'hF;

  localparam logic [3:0] SEN_RST  = 4'hF;
  localparam logic       SSEL_RST = 1'b0;
  localparam logic [3:0] MASK_RST = 4'hF;

endpackage

// File: rtl/gmux_dwell_cnt.sv
// rtl/gmux_dwell_cnt.sv - 4-bit loadable down-counter with zero flag
//
// Purpose: times the gate and settle dwell intervals of gmux_sel_ctrl.
// Ports:
//   CLK        in  clock, rising edge
//   RST        in  asynchronous active-high reset (count -> 0)
//   i_load     in  load i_load_val (has priority over i_dec)
//   i_load_val in  value to load
//   i_dec      in  decrement by one, saturating at zero
//   o_zero     out count is zero
module gmux_dwell_cnt (
  input  logic       CLK,
  input  logic       RST,
  input  logic       i_load,
  input  logic [3:0] i_load_val,
  input  logic       i_dec,
  output logic       o_zero
);

  logic [3:0] r_cnt;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_cnt <= 4'd0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != 4'd0)) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  assign o_zero = (r_cnt == 4'd0);

endmodule

// File: rtl/gmux_sel_ctrl.sv
// rtl/gmux_sel_ctrl.sv - glitch-free GMUX source switch and quadrant enable sequencer
//
// Purpose: gates all quadrants, changes SSEL, waits for the mux to settle and
//          re-enables the requested quadrants; also handles a low-power mode.
// Ports:
//   CLK, RST          clock (rising) and asynchronous active-high reset
//   REQ_VALID/READY   reconfiguration handshake
//   REQ_SRC, REQ_QEN  requested source and quadrant enable mask
//   DONE              one-cycle completion pulse
//   LP_REQ            level low-power request
//   BUSY              controller not idle
//   SSEL              GMUX source select
//   SEN/DEN/DYNEN/VLP quadrant controls (bit 0=TL,1=TR,2=BL,3=BR)
module gmux_sel_ctrl #(
  parameter int GATE_CYC   = 2,
  parameter int SETTLE_CYC = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       REQ_VALID,
  input  logic       REQ_SRC,
  input  logic [3:0] REQ_QEN,
  output logic       REQ_READY,
  output logic       DONE,
  input  logic       LP_REQ,
  output logic       BUSY,
  output logic       SSEL,
  output logic [3:0] SEN,
  output logic [3:0] DEN,
  output logic [3:0] DYNEN,
  output logic [3:0] VLP
);

  import gmux_ctrl_pkg::*;

  localparam logic [3:0] GATE_LD   = 4'(GATE_CYC - 1);
  localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYC - 1);

  gmux_state_e r_state, w_state_nxt;
  logic        r_ssel, w_ssel_nxt;
  logic [3:0]  r_sen, w_sen_nxt;
  logic [3:0]  r_dynen, w_dynen_nxt;
  logic [3:0]  r_vlp, w_vlp_nxt;
  logic        r_done, w_done_nxt;
  logic        r_src, w_src_nxt;
  logic [3:0]  r_mask, w_mask_nxt;
  // Set while settling out of low power: that path restores SEN silently
  logic        r_lp_exit, w_lp_exit_nxt;

  logic        w_cnt_load;
  logic [3:0]  w_cnt_val;
  logic        w_cnt_dec;
  logic        w_cnt_zero;

  gmux_dwell_cnt u_dwell_cnt (
    .CLK       (CLK),
    .RST       (RST),
    .i_load    (w_cnt_load),
    .i_load_val(w_cnt_val),
    .i_dec     (w_cnt_dec),
    .o_zero    (w_cnt_zero)
  );

  assign REQ_READY = (r_state == ST_IDLE) && !RST;
  assign BUSY      = (r_state != ST_IDLE);
  assign DONE      = r_done;
  assign SSEL      = r_ssel;
  assign SEN       = r_sen;
  assign DEN       = Q_NONE;
  assign DYNEN     = r_dynen;
  assign VLP       = r_vlp;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state   <= ST_IDLE;
      r_ssel    <= SSEL_RST;
      r_sen     <= SEN_RST;
      r_dynen   <= Q_NONE;
      r_vlp     <= Q_NONE;
      r_done    <= 1'b0;
      r_src     <= SSEL_RST;
      r_mask    <= MASK_RST;
      r_lp_exit <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_ssel    <= w_ssel_nxt;
      r_sen     <= w_sen_nxt;
      r_dynen   <= w_dynen_nxt;
      r_vlp     <= w_vlp_nxt;
      r_done    <= w_done_nxt;
      r_src     <= w_src_nxt;
      r_mask    <= w_mask_nxt;
      r_lp_exit <= w_lp_exit_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_ssel_nxt    = r_ssel;
    w_sen_nxt     = r_sen;
    w_vlp_nxt     = r_vlp;
    w_done_nxt    = 1'b0;
    w_src_nxt     = r_src;
    w_mask_nxt    = r_mask;
    w_lp_exit_nxt = r_lp_exit;
    w_cnt_load    = 1'b0;
    w_cnt_val     = 4'd0;
    w_cnt_dec     = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (REQ_VALID && REQ_READY) begin
          w_src_nxt  = REQ_SRC;
          w_mask_nxt = REQ_QEN;
          if (REQ_SRC == r_ssel) begin
            // Same source: no mux change, so enables can update at once
            w_sen_nxt  = REQ_QEN;
            w_done_nxt = 1'b1;
          end else begin
            w_sen_nxt     = Q_NONE;
            w_lp_exit_nxt = 1'b0;
            w_state_nxt   = ST_GATE;
            w_cnt_load    = 1'b1;
            w_cnt_val     = GATE_LD;
          end
        end else if (LP_REQ) begin
          w_sen_nxt   = Q_NONE;
          w_vlp_nxt   = Q_ALL;
          w_state_nxt = ST_LP;
        end
      end
      ST_GATE: begin
        if (w_cnt_zero) begin
          // All quadrants have been gated for GATE_CYC cycles; safe to switch
          w_ssel_nxt  = r_src;
          w_state_nxt = ST_SETTLE;
          w_cnt_load  = 1'b1;
          w_cnt_val   = SETTLE_LD;
        end else begin
          w_cnt_dec = 1'b1;
        end
      end
      ST_SETTLE: begin
        if (w_cnt_zero) begin
          w_sen_nxt     = r_mask;
          w_done_nxt    = !r_lp_exit;
          w_lp_exit_nxt = 1'b0;
          w_state_nxt   = ST_IDLE;
        end else begin
          w_cnt_dec = 1'b1;
        end
      end
      ST_LP: begin
        if (!LP_REQ) begin
          w_vlp_nxt     = Q_NONE;
          w_lp_exit_nxt = 1'b1;
          w_state_nxt   = ST_SETTLE;
          w_cnt_load    = 1'b1;
          w_cnt_val     = SETTLE_LD;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    // Registered alongside the state so DYNEN tracks GATE/SETTLE exactly
    if ((w_state_nxt == ST_GATE) || (w_state_nxt == ST_SETTLE)) begin
      w_dynen_nxt = w_mask_nxt;
    end else begin
      w_dynen_nxt = Q_NONE;
    end
  end

endmodule
